// File: rtl/canvas_cmd_unit.sv
// rtl/canvas_cmd_unit.sv - command FIFO and executor driving frame-buffer, palette and scroll ports
// Optional FILL opcode enabled by defining CANVAS_CMD_FILL_EN.
module canvas_cmd_unit (
    input  logic        i_cmd_clk,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    input  logic [31:0] i_cmd_data,
    output logic        o_cmd_ready,
    output logic        o_fb_we,
    output logic [8:0]  o_fb_col,
    output logic [7:0]  o_fb_row,
    output logic [7:0]  o_fb_data,
    output logic        o_pal_we,
    output logic [7:0]  o_pal_index,
    output logic [11:0] o_pal_color,
    output logic [9:0]  o_scroll_x,
    output logic [8:0]  o_scroll_y,
    output logic        o_busy,
    output logic [7:0]  o_err_count
);

    logic [31:0] fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  fifo_count;
    logic        push;
    logic        pop;
    logic [31:0] cmd;
    logic [3:0]  opcode;
    logic [8:0]  addr_col;
    logic [7:0]  addr_row;
    logic [8:0]  next_col;
    logic [7:0]  next_row;
    logic        unused_bits;

`ifdef CANVAS_CMD_FILL_EN
    typedef enum logic {ST_IDLE, ST_FILL} state_t;
    state_t      state;
    logic [16:0] fill_left;
    logic [7:0]  fill_color;
    logic [16:0] fill_len;
    assign fill_len = cmd[24:8];
    assign pop      = (state == ST_IDLE) && (fifo_count != 3'd0);
`else
    assign pop      = (fifo_count != 3'd0);
    assign o_busy   = 1'b0;
`endif

    // Ready depends only on occupancy so a full FIFO stays closed even while popping.
    assign o_cmd_ready = (fifo_count != 3'd4);
    assign push        = i_cmd_valid && o_cmd_ready;
    assign cmd         = fifo_mem[rd_ptr];
    assign opcode      = cmd[31:28];
    assign unused_bits = ^cmd[27:20];

    assign next_col = addr_col + 9'd1;
    assign next_row = (addr_col == 9'h1FF) ? addr_row + 8'd1 : addr_row;

    always_ff @(posedge i_cmd_clk) begin
        if (push) fifo_mem[wr_ptr] <= i_cmd_data;
    end

    always_ff @(posedge i_cmd_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr      <= 2'd0;
            rd_ptr      <= 2'd0;
            fifo_count  <= 3'd0;
            addr_col    <= 9'd0;
            addr_row    <= 8'd0;
            o_fb_we     <= 1'b0;
            o_fb_col    <= 9'd0;
            o_fb_row    <= 8'd0;
            o_fb_data   <= 8'd0;
            o_pal_we    <= 1'b0;
            o_pal_index <= 8'd0;
            o_pal_color <= 12'd0;
            o_scroll_x  <= 10'd0;
            o_scroll_y  <= 9'd0;
            o_err_count <= 8'd0;
`ifdef CANVAS_CMD_FILL_EN
            state       <= ST_IDLE;
            fill_left   <= 17'd0;
            fill_color  <= 8'd0;
            o_busy      <= 1'b0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase

            o_fb_we  <= 1'b0;
            o_pal_we <= 1'b0;
`ifdef CANVAS_CMD_FILL_EN
            o_busy   <= 1'b0;
            if (state == ST_FILL) begin
                o_fb_we   <= 1'b1;
                o_busy    <= 1'b1;
                o_fb_col  <= addr_col;
                o_fb_row  <= addr_row;
                o_fb_data <= fill_color;
                addr_col  <= next_col;
                addr_row  <= next_row;
                fill_left <= fill_left - 17'd1;
                if (fill_left == 17'd1) state <= ST_IDLE;
            end else
`endif
            if (pop) begin
                case (opcode)
                    4'h0: ;
                    4'h1: begin
                        addr_col <= cmd[8:0];
                        addr_row <= cmd[16:9];
                    end
                    4'h2: begin
                        o_fb_we   <= 1'b1;
                        o_fb_col  <= addr_col;
                        o_fb_row  <= addr_row;
                        o_fb_data <= cmd[7:0];
                        addr_col  <= next_col;
                        addr_row  <= next_row;
                    end
`ifdef CANVAS_CMD_FILL_EN
                    // The first fill pixel is written on the popping edge itself.
                    4'h3: begin
                        if (fill_len != 17'd0) begin
                            o_fb_we    <= 1'b1;
                            o_busy     <= 1'b1;
                            o_fb_col   <= addr_col;
                            o_fb_row   <= addr_row;
                            o_fb_data  <= cmd[7:0];
                            addr_col   <= next_col;
                            addr_row   <= next_row;
                            fill_color <= cmd[7:0];
                            fill_left  <= fill_len - 17'd1;
                            if (fill_len != 17'd1) state <= ST_FILL;
                        end
                    end
`endif
                    4'h4: begin
                        o_pal_we    <= 1'b1;
                        o_pal_index <= cmd[19:12];
                        o_pal_color <= cmd[11:0];
                    end
                    4'h5: o_scroll_x <= cmd[9:0];
                    4'h6: o_scroll_y <= cmd[8:0];
                    default: begin
                        if (o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_canvas_cmd_unit.sv
// tb/tb_canvas_cmd_unit.sv - scoreboard bench for canvas_cmd_unit
module tb_canvas_cmd_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_data = 32'd0;
    logic        cmd_ready;
    logic        fb_we;
    logic [8:0]  fb_col;
    logic [7:0]  fb_row;
    logic [7:0]  fb_data;
    logic        pal_we;
    logic [7:0]  pal_index;
    logic [11:0] pal_color;
    logic [9:0]  scroll_x;
    logic [8:0]  scroll_y;
    logic        busy;
    logic [7:0]  err_count;

    canvas_cmd_unit dut (
        .i_cmd_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .i_cmd_data(cmd_data),
        .o_cmd_ready(cmd_ready), .o_fb_we(fb_we), .o_fb_col(fb_col), .o_fb_row(fb_row),
        .o_fb_data(fb_data), .o_pal_we(pal_we), .o_pal_index(pal_index), .o_pal_color(pal_color),
        .o_scroll_x(scroll_x), .o_scroll_y(scroll_y), .o_busy(busy), .o_err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] col;
        logic [7:0] row;
        logic [7:0] data;
        logic       busy;
    } fb_t;

    fb_t         fb_q [$];
    logic [19:0] pal_q [$];
    int errors = 0;
    int checks = 0;
    int busy_cnt = 0;
    int sent_cnt = 0;
    int stall_at = -1;
    int err_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_px(input int col, input int row, input int data, input logic b);
        fb_t e;
        e.col = col[8:0];
        e.row = row[7:0];
        e.data = data[7:0];
        e.busy = b;
        fb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (fb_we) begin
                if (fb_q.size() == 0) begin
                    check("unexpected_fb_we", {9'd0, fb_col, fb_row, fb_data}, 32'd0);
                end else begin
                    fb_t e;
                    e = fb_q.pop_front();
                    check("fb_col", {23'd0, fb_col}, {23'd0, e.col});
                    check("fb_row", {24'd0, fb_row}, {24'd0, e.row});
                    check("fb_data", {24'd0, fb_data}, {24'd0, e.data});
                    check("fb_busy", {31'd0, busy}, {31'd0, e.busy});
                end
            end else if (busy) begin
                check("busy_without_we", {31'd0, busy}, 32'd0);
            end
            if (pal_we) begin
                if (pal_q.size() == 0) begin
                    check("unexpected_pal_we", {12'd0, pal_index, pal_color}, 32'd0);
                end else begin
                    logic [19:0] p;
                    p = pal_q.pop_front();
                    check("pal_index", {24'd0, pal_index}, {24'd0, p[19:12]});
                    check("pal_color", {20'd0, pal_color}, {20'd0, p[11:0]});
                end
            end
        end
    end

    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data = w;
        if (!cmd_ready && stall_at < 0) stall_at = sent_cnt;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        sent_cnt++;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        idle(0);
        while ((fb_q.size() != 0 || pal_q.size() != 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) check("drain_timeout", fb_q.size(), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_zero_outputs"},
              {29'd0, fb_we, pal_we, busy}, 32'd0);
        check({tag, "_fb_addr_data"}, {7'd0, fb_col, fb_row, fb_data}, 32'd0);
        check({tag, "_pal"}, {12'd0, pal_index, pal_color}, 32'd0);
        check({tag, "_scroll"}, {13'd0, scroll_x, scroll_y}, 32'd0);
        check({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
        check({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // pixel writes with address advance, then column/row wrap
        send(32'h10000605);
        exp_px(5, 3, 8'hAB, 1'b0); send(32'h200000AB);
        exp_px(6, 3, 8'hCD, 1'b0); send(32'h200000CD);
        send(32'h1001FFFF);
        exp_px(511, 255, 8'h12, 1'b0); send(32'h20000012);
        exp_px(0, 0, 8'h34, 1'b0); send(32'h20000034);
        drain(100);

`ifdef CANVAS_CMD_FILL_EN
        busy_cnt = 0;
        send(32'h100001FE);
        exp_px(510, 0, 8'h11, 1'b1);
        exp_px(511, 0, 8'h11, 1'b1);
        exp_px(0, 1, 8'h11, 1'b1);
        exp_px(1, 1, 8'h11, 1'b1);
        send(32'h30000411);
        drain(100);
        check("fill4_busy_cycles", busy_cnt, 32'd4);

        busy_cnt = 0;
        send(32'h30000022);
        idle(6);
        check("fill0_busy_cycles", busy_cnt, 32'd0);

        send(32'h10001400);
        for (int i = 0; i < 40; i++) exp_px(i, 10, 8'h77, 1'b1);
        for (int i = 0; i < 6; i++) exp_px(40 + i, 10, 8'hA0 + i, 1'b0);
        send(32'h30002877);
        sent_cnt = 0;
        stall_at = -1;
        for (int i = 0; i < 6; i++) send(32'h200000A0 + i);
        drain(200);
        check("burst_accepted_before_stall", stall_at, 32'd4);
`else
        send(32'h100001FE);
        send(32'h30000411);
        idle(4);
        err_exp++;
        check("fill_as_unknown_err", {24'd0, err_count}, err_exp);
        send(32'h30000022);
        idle(4);
        err_exp++;
        check("fill0_as_unknown_err", {24'd0, err_count}, err_exp);
        check("busy_tied_low", {31'd0, busy}, 32'd0);
`endif

        pal_q.push_back(20'h80F0A);
        send(32'h40080F0A);
        send(32'h0FFFFFFF);
        send(32'h500003FF);
        send(32'h6ABC0123);
        drain(100);
        check("scroll_x", {22'd0, scroll_x}, 32'd1023);
        check("scroll_y", {23'd0, scroll_y}, 32'h123);

        send(32'h70000000);
        idle(4);
        err_exp++;
        check("err_after_op7", {24'd0, err_count}, err_exp);
        for (int i = 0; i < 300; i++) send(32'hF0000000 + i);
        idle(6);
        check("err_saturated", {24'd0, err_count}, 32'd255);
        send(32'h500001AA);
        idle(4);

`ifdef CANVAS_CMD_FILL_EN
        send(32'h10000000);
        for (int i = 0; i < 100; i++) exp_px(i, 0, 8'h5A, 1'b1);
        send(32'h3000645A);
        idle(0);
        begin
            int n;
            n = 0;
            while (fb_q.size() > 90 && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (n >= 200) check("midfill_timeout", fb_q.size(), 32'd90);
        end
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        fb_q.delete();
        pal_q.delete();
        #1;
        check_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check_zero("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
